// File: rtl/fp_pkg.sv
// fp_pkg: shared floating-point format defaults, flag bit indices, operand classes and helpers
package fp_pkg;
  localparam int EXP_W_DEF = 5;
  localparam int MAN_W_DEF = 10;
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UDF = 1;
  localparam int FLG_INX = 0;
  typedef enum logic [2:0] {ZERO, SUB, NORM, INF, QNAN, SNAN} fp_class_e;
  function automatic logic [63:0] qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: leading-zero counter, returns W when the input is all zeros
module fp_lzc #(
  parameter int W = 14,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_val,
  output logic [CW-1:0] o_cnt
);
  // highest set bit wins because later loop iterations override earlier ones
  always_comb begin
    o_cnt = CW'(W);
    for (int i = 0; i < W; i++) if (i_val[i]) o_cnt = CW'(W - 1 - i);
  end
endmodule

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage IEEE-754 style adder/subtractor with RNE, subnormals, flags and valid/ready
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  input  logic         i_vld,
  output logic         o_rdy,
  output logic [W-1:0] o_res,
  output logic [3:0]   o_flags,
  output logic         o_res_vld,
  input  logic         i_res_rdy
);
  localparam int M = MAN_W + 4;
  localparam int E = EXP_W + 1;
  localparam int LZ_W = $clog2(M + 1);
  localparam logic [W-1:0] QN = W'(qnan(EXP_W, MAN_W));
  typedef struct packed {
    logic             vld;
    logic             sign;
    logic             eff_sub;
    logic             spec;
    logic             inv;
    logic [EXP_W-1:0] exp;
    logic [W-1:0]     spec_res;
  } hdr_t;
  typedef struct packed {
    hdr_t         h;
    logic [M-1:0] ml;
    logic [M-1:0] ms;
  } s1_t;
  typedef struct packed {
    hdr_t       h;
    logic [M:0] sum;
  } s2_t;
  function automatic fp_class_e classify(input logic [W-1:0] x);
    if (&x[W-2:MAN_W]) return (x[MAN_W-1:0] == '0) ? INF : (x[MAN_W-1] ? QNAN : SNAN);
    if (x[W-2:MAN_W] == '0) return (x[MAN_W-1:0] == '0) ? ZERO : SUB;
    return NORM;
  endfunction
  logic w_adv;
  logic [W-1:0] w_b, w_l;
  logic [W-2:0] w_s;
  fp_class_e w_ca, w_cb;
  logic w_swap, w_nan, w_ii, w_stk;
  logic [EXP_W-1:0] w_el, w_es, w_d, w_sh;
  logic [M-1:0] w_ms_raw, w_ms;
  s1_t w_s1, r_s1;
  logic [M:0] w_sum;
  s2_t w_s2, r_s2;
  logic [LZ_W-1:0] w_lz;
  logic w_cy, w_up, w_inx, w_ovf, w_zs;
  logic [E-1:0] w_e0, w_lim, w_lze, w_nsh, w_e1, w_ef;
  logic [M-1:0] w_norm;
  logic [MAN_W+1:0] w_mr;
  logic [MAN_W-1:0] w_mf;
  logic [W-1:0] w_res3, r_res;
  logic [3:0] w_flg3, r_flg;
  logic r_res_vld;
  assign w_adv = ~r_res_vld | i_res_rdy;
  assign o_rdy = w_adv;
  assign o_res = r_res;
  assign o_flags = r_flg;
  assign o_res_vld = r_res_vld;
  assign w_b = {i_b[W-1] ^ i_sub, i_b[W-2:0]};
  // S1: classify, put the larger magnitude first and align the smaller one with guard/round/sticky
  always_comb begin
    w_ca = classify(i_a);
    w_cb = classify(w_b);
    w_swap = w_b[W-2:0] > i_a[W-2:0];
    w_l = w_swap ? w_b : i_a;
    w_s = w_swap ? i_a[W-2:0] : w_b[W-2:0];
    w_el = (w_l[W-2:MAN_W] == '0) ? EXP_W'(1) : w_l[W-2:MAN_W];
    w_es = (w_s[W-2:MAN_W] == '0) ? EXP_W'(1) : w_s[W-2:MAN_W];
    w_d = w_el - w_es;
    w_sh = (w_d > EXP_W'(M - 1)) ? EXP_W'(M - 1) : w_d;
    w_ms_raw = {(w_s[W-2:MAN_W] != '0), w_s[MAN_W-1:0], 3'b000};
    w_ms = w_ms_raw >> w_sh;
    w_stk = |(w_ms_raw & ~({M{1'b1}} << w_sh));
    w_nan = (w_ca == QNAN) | (w_ca == SNAN) | (w_cb == QNAN) | (w_cb == SNAN);
    w_ii = (w_ca == INF) & (w_cb == INF) & (i_a[W-1] ^ w_b[W-1]);
    w_s1.h.vld = i_vld;
    w_s1.h.sign = w_l[W-1];
    w_s1.h.eff_sub = i_a[W-1] ^ w_b[W-1];
    w_s1.h.spec = w_nan | (w_ca == INF) | (w_cb == INF);
    w_s1.h.inv = (w_ca == SNAN) | (w_cb == SNAN) | w_ii;
    w_s1.h.exp = w_el;
    w_s1.h.spec_res = (w_nan | w_ii) ? QN : ((w_ca == INF) ? i_a : w_b);
    w_s1.ml = {(w_l[W-2:MAN_W] != '0), w_l[MAN_W-1:0], 3'b000};
    w_s1.ms = {w_ms[M-1:1], w_ms[0] | w_stk};
  end
  // S1 register: every stage loads together only when the output can advance
  always_ff @(posedge clk or posedge rst)
    if (rst) r_s1 <= '0;
    else if (w_adv) r_s1 <= w_s1;
  // S2: magnitude add/sub; the swap guarantees ml >= ms so the difference never goes negative
  assign w_sum = r_s1.h.eff_sub ? {1'b0, r_s1.ml} - {1'b0, r_s1.ms} : {1'b0, r_s1.ml} + {1'b0, r_s1.ms};
  assign w_s2 = {r_s1.h, w_sum};
  // S2 register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_s2 <= '0;
    else if (w_adv) r_s2 <= w_s2;
  fp_lzc #(.W(M)) u_lzc (.i_val(r_s2.sum[M-1:0]), .o_cnt(w_lz));
  // S3: normalise (left shift capped so exponent stays >= 1), RNE round, repack and special-case mux
  always_comb begin
    w_cy = r_s2.sum[M];
    w_e0 = {1'b0, r_s2.h.exp};
    w_lim = w_e0 - E'(1);
    w_lze = E'(w_lz);
    w_nsh = w_cy ? '0 : ((w_lze < w_lim) ? w_lze : w_lim);
    w_norm = w_cy ? {r_s2.sum[M:2], r_s2.sum[1] | r_s2.sum[0]} : r_s2.sum[M-1:0] << w_nsh;
    w_e1 = w_cy ? w_e0 + E'(1) : w_e0 - w_nsh;
    w_inx = |w_norm[2:0];
    w_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mr = {1'b0, w_norm[M-1:3]} + (MAN_W+2)'(w_up);
    w_ef = w_mr[MAN_W+1] ? w_e1 + E'(1) : (w_mr[MAN_W] ? w_e1 : '0);
    w_mf = w_mr[MAN_W+1] ? w_mr[MAN_W:1] : w_mr[MAN_W-1:0];
    w_ovf = w_ef >= E'((1 << EXP_W) - 1);
    w_zs = ((r_s2.sum == '0) & r_s2.h.eff_sub) ? 1'b0 : r_s2.h.sign;
    w_res3 = r_s2.h.spec ? r_s2.h.spec_res :
             w_ovf ? {r_s2.h.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {w_zs, w_ef[EXP_W-1:0], w_mf};
    w_flg3 = '0;
    w_flg3[FLG_INV] = r_s2.h.spec & r_s2.h.inv;
    w_flg3[FLG_OVF] = ~r_s2.h.spec & w_ovf;
    w_flg3[FLG_UDF] = ~r_s2.h.spec & ~w_ovf & (w_ef == '0) & w_inx;
    w_flg3[FLG_INX] = ~r_s2.h.spec & (w_inx | w_ovf);
  end
  // S3 register: result, flags and valid presented to the consumer
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_res_vld <= 1'b0;
      r_res <= '0;
      r_flg <= '0;
    end else if (w_adv) begin
      r_res_vld <= r_s2.h.vld;
      r_res <= w_res3;
      r_flg <= w_flg3;
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed vectors for binary16 and binary32 instances, backpressure and reset flush
module tb_fp_addsub_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] a16 = '0, b16 = '0, res16;
  logic sub16 = 1'b0, vld16 = 1'b0, rr16 = 1'b1, rdy16, rv16;
  logic [3:0] flg16;
  logic [31:0] a32 = '0, b32 = '0, res32;
  logic sub32 = 1'b0, vld32 = 1'b0, rr32 = 1'b1, rdy32, rv32;
  logic [3:0] flg32;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) u16 (
    .clk(clk), .rst(rst), .i_a(a16), .i_b(b16), .i_sub(sub16), .i_vld(vld16), .o_rdy(rdy16),
    .o_res(res16), .o_flags(flg16), .o_res_vld(rv16), .i_res_rdy(rr16)
  );
  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) u32 (
    .clk(clk), .rst(rst), .i_a(a32), .i_b(b32), .i_sub(sub32), .i_vld(vld32), .o_rdy(rdy32),
    .o_res(res32), .o_flags(flg32), .o_res_vld(rv32), .i_res_rdy(rr32)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic xact(input bit f32, input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [31:0] er, input logic [3:0] ef, input string tag);
    int n;
    @(negedge clk);
    if (f32) begin
      a32 = a; b32 = b; sub32 = sub; vld32 = 1'b1;
    end else begin
      a16 = a[15:0]; b16 = b[15:0]; sub16 = sub; vld16 = 1'b1;
    end
    @(posedge clk);
    #1;
    vld16 = 1'b0;
    vld32 = 1'b0;
    n = 1;
    while (!(f32 ? rv32 : rv16) && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, n, 3);
    chk({tag, "_res"}, f32 ? res32 : {16'h0, res16}, er);
    chk({tag, "_flg"}, {28'h0, f32 ? flg32 : flg16}, {28'h0, ef});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] held;
    bit stall_prev;
    int sent, recv, stale;
    repeat (2) @(negedge clk);
    chk("rst_vld16", {31'h0, rv16}, 0);
    chk("rst_res16", {16'h0, res16}, 0);
    chk("rst_flg16", {28'h0, flg16}, 0);
    chk("rst_vld32", {31'h0, rv32}, 0);
    chk("rst_res32", res32, 0);
    rst = 1'b0;
    #1;
    chk("rst_rdy16", {31'h0, rdy16}, 1);
    xact(0, 32'h3C00, 32'h3C00, 0, 32'h4000, 4'h0, "h_1p1");
    xact(0, 32'h3C00, 32'h3C00, 1, 32'h0000, 4'h0, "h_xmx");
    xact(0, 32'h8000, 32'h8000, 0, 32'h8000, 4'h0, "h_nznz");
    xact(0, 32'h0000, 32'h8000, 0, 32'h0000, 4'h0, "h_pznz");
    xact(0, 32'h3C00, 32'h1000, 0, 32'h3C00, 4'h1, "h_tie_even");
    xact(0, 32'h3C01, 32'h1000, 0, 32'h3C02, 4'h1, "h_tie_up");
    xact(0, 32'h3C00, 32'h4000, 1, 32'hBC00, 4'h0, "h_1m2");
    xact(0, 32'h7C00, 32'hFC00, 0, 32'h7E00, 4'h8, "h_infminf");
    xact(0, 32'h7BFF, 32'h7BFF, 0, 32'h7C00, 4'h5, "h_ovf");
    xact(0, 32'h7D00, 32'h3C00, 0, 32'h7E00, 4'h8, "h_snan");
    xact(0, 32'h7E00, 32'h3C00, 0, 32'h7E00, 4'h0, "h_qnan");
    xact(0, 32'h3C00, 32'h7C00, 1, 32'hFC00, 4'h0, "h_fminf");
    xact(0, 32'h0001, 32'h0001, 0, 32'h0002, 4'h0, "h_sub");
    xact(0, 32'h0400, 32'h0001, 1, 32'h03FF, 4'h0, "h_tosub");
    xact(1, 32'h3F800000, 32'h3F800000, 0, 32'h40000000, 4'h0, "s_1p1");
    xact(1, 32'h3F800000, 32'h3F800000, 1, 32'h00000000, 4'h0, "s_xmx");
    xact(1, 32'h80000000, 32'h80000000, 0, 32'h80000000, 4'h0, "s_nznz");
    xact(1, 32'h3F800000, 32'h33800000, 0, 32'h3F800000, 4'h1, "s_tie_even");
    xact(1, 32'h3F800001, 32'h33800000, 0, 32'h3F800002, 4'h1, "s_tie_up");
    sent = 0;
    recv = 0;
    stall_prev = 0;
    held = '0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      rr16 = !(t >= 4 && t <= 8);
      vld16 = (sent < 6);
      a16 = 16'h4000 + 16'(sent);
      b16 = 16'h0000;
      sub16 = 1'b0;
      #1;
      if (rv16 && !rr16) begin
        chk("bp_rdy_low", {31'h0, rdy16}, 0);
        if (stall_prev) chk("bp_hold", {16'h0, res16}, {16'h0, held});
        held = res16;
        stall_prev = 1;
      end else stall_prev = 0;
      if (rv16 && rr16) begin
        if (recv < 6) chk("bp_order", {16'h0, res16}, 32'h4000 + recv);
        recv++;
      end
      if (vld16 && rdy16) sent++;
    end
    vld16 = 1'b0;
    rr16 = 1'b1;
    chk("bp_sent", sent, 6);
    chk("bp_recv", recv, 6);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vld16 = 1'b1;
      a16 = 16'h3C00;
      b16 = 16'h3C00;
      sub16 = 1'b0;
    end
    @(negedge clk);
    vld16 = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_flush_vld", {31'h0, rv16}, 0);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (rv16) stale++;
    end
    chk("rst_no_stale", stale, 0);
    chk("rst_rdy_after", {31'h0, rdy16}, 1);
    xact(0, 32'h3C00, 32'h3C00, 0, 32'h4000, 4'h0, "h_post_rst");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
